regfile_mp: RTL and testbench
=============================

REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameter DATA_W, default 32, sets the register data width in bits.
REQ-002 Parameter ADDR_W, default 5, sets the address width; depth is 2**ADDR_W registers.
REQ-003 Parameter NREAD, default 2, sets the number of independent read ports (1..4).
REQ-004 The reset is synchronous and active-low, and the block uses a single clock.
REQ-005 Port clk, input, 1 bit: the single clock; every state change happens on its rising edge.
REQ-006 Port rst_n, input, 1 bit: synchronous active-low reset.
REQ-007 Port we0, input, 1 bit: write-enable for write port 0.
REQ-008 Port waddr0, input, ADDR_W bits: destination address for write port 0.
REQ-009 Port wdata0, input, DATA_W bits: write data for write port 0.
REQ-010 Ports we1, waddr1 and wdata1 SHALL have the same directions and widths as write port 0 and serve write port 1.
REQ-011 Port alloc_en, input, 1 bit: marks register alloc_addr as pending, meaning a producer is in flight.
REQ-012 Port alloc_addr, input, ADDR_W bits: the register to mark pending.
REQ-013 Port raddr, input, NREAD*ADDR_W bits: packed read addresses; port i occupies bits [i*ADDR_W +: ADDR_W].
REQ-014 Port rdata, output, NREAD*DATA_W bits: packed combinational read data, indexed the same way as raddr.
REQ-015 Port rbusy, output, NREAD bits: per-port flag meaning "operand not yet valid".

Function
REQ-016 Register 0 SHALL read as 0 at all times, and writes or allocations to address 0 SHALL be ignored.
REQ-017 A write on port p (wep=1, waddrp≠0) SHALL update the register on the next rising edge of clk.
REQ-018 If both ports write the same nonzero address in the same cycle, port 1's data SHALL be stored and port 0's discarded.
REQ-019 Read data SHALL be combinational from the array, with zero read latency.
REQ-020 The scoreboard SHALL hold one pending bit per register; alloc_en sets pending[alloc_addr] at the next edge.
REQ-021 A write on either port to address A SHALL clear pending[A] at the next edge.
REQ-022 If an alloc and a write target the same address in the same cycle, the alloc SHALL win and pending stays 1, because a new producer supersedes the old one.
REQ-023 Re-allocating an already pending register SHALL leave it pending, with no error.
REQ-024 rbusy[i] SHALL equal pending[raddr_i], qualified as specified under Configuration; rbusy for address 0 SHALL always be 0.
REQ-025 All read ports SHALL operate independently; several ports reading the same address SHALL return identical data.

Reset
REQ-026 While rst_n=0 at a rising edge, all registers SHALL clear to 0 and all pending bits SHALL clear to 0.
REQ-027 While in reset, rdata SHALL be all 0 and rbusy SHALL be all 0 from the first edge after rst_n falls.
REQ-028 Writes and allocs presented in a reset cycle SHALL be discarded, and reset SHALL take priority mid-operation.

Configuration
REQ-029 Macro REGFILE_BYPASS_EN SHALL, when defined, forward write data to reads in the same cycle (write-first behaviour).
REQ-030 With REGFILE_BYPASS_EN defined: if raddr_i matches an enabled nonzero write address, rdata_i SHALL be that write's data (port 1 over port 0), and rbusy_i SHALL be 0.
REQ-031 Without REGFILE_BYPASS_EN: rdata_i SHALL be the stored value (read-first), and rbusy_i SHALL be the raw pending[raddr_i].

Structure
REQ-032 A package regfile_pkg SHALL hold the default constants (DATA_W_DEF=32, ADDR_W_DEF=5, NREAD_MAX=4) and a zero-register address constant.
REQ-033 The scoreboard SHALL be a sub-module, regfile_scoreboard, owning the pending bits and the set/clear priority logic.
REQ-034 The register array, write-port priority, and read and bypass muxes SHALL remain in regfile_mp.

Verification
REQ-035 Reset then read: after reset, read every address on all ports -> rdata=0 and rbusy=0 everywhere.
REQ-036 Dual write, same address: we0 writes 0x11111111 and we1 writes 0x22222222 to address 5 in the same cycle; next cycle read 5 -> 0x22222222.
REQ-037 Zero register: write 0xDEADBEEF to address 0 and alloc address 0 -> reading 0 gives 0 with rbusy=0.
REQ-038 Scoreboard: alloc 7; next cycle read 7 -> rbusy=1. Write 7=0xA5A5A5A5; in that same cycle rbusy=0 and rdata=0xA5A5A5A5 with bypass on (rbusy=1 and the old value with bypass off); the cycle after that -> rbusy=0 and rdata=0xA5A5A5A5 in both builds.
REQ-039 Alloc/write collision: alloc 9 and write 9=0x1234 in the same cycle -> next cycle rbusy=1 and rdata=0x1234.
REQ-040 Reset mid-operation: with registers 3 and 4 pending and holding data, assert rst_n=0 for one cycle together with a write to 3 -> all data 0, no register pending, and the write discarded.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg -- shared constants for the multi-port register file.
//   DATA_W_DEF : default register width in bits
//   ADDR_W_DEF : default address width (depth = 2**ADDR_W)
//   NREAD_MAX  : largest supported number of read ports
//   REG_ZERO   : address of the hard-wired zero register
package regfile_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned NREAD_MAX  = 4;
  localparam int unsigned REG_ZERO   = 0;

endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard -- one pending bit per register, marking registers whose
// producer is still in flight.
//   clk, rst_n           : clock, synchronous active-low reset
//   alloc_en, alloc_addr : set pending[alloc_addr] at the next edge
//   clr0_en, clr0_addr   : write port 0, clears pending[clr0_addr]
//   clr1_en, clr1_addr   : write port 1, clears pending[clr1_addr]
//   pending              : current pending bits, bit 0 always 0
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   alloc_en,
  input  logic [ADDR_W-1:0]      alloc_addr,
  input  logic                   clr0_en,
  input  logic [ADDR_W-1:0]      clr0_addr,
  input  logic                   clr1_en,
  input  logic [ADDR_W-1:0]      clr1_addr,
  output logic [2**ADDR_W-1:0]   pending
);

  logic [2**ADDR_W-1:0] pending_nxt;

  // Clears are applied before the set so that a new allocation supersedes a
  // completing producer of the same register.
  always_comb begin
    pending_nxt = pending;
    if (clr0_en) pending_nxt[clr0_addr] = 1'b0;
    if (clr1_en) pending_nxt[clr1_addr] = 1'b0;
    if (alloc_en) pending_nxt[alloc_addr] = 1'b1;
    pending_nxt[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) pending <= '0;
    else        pending <= pending_nxt;
  end

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp -- register file with two write ports, NREAD combinational read
// ports and a pending-producer scoreboard. Register 0 reads as zero.
//   clk, rst_n              : clock, synchronous active-low reset
//   we0, waddr0, wdata0     : write port 0
//   we1, waddr1, wdata1     : write port 1 (wins over port 0 on same address)
//   alloc_en, alloc_addr    : mark a register pending
//   raddr                   : packed read addresses, port i at [i*ADDR_W +: ADDR_W]
//   rdata                   : packed read data, port i at [i*DATA_W +: DATA_W]
//   rbusy                   : per-port "operand not yet valid"
// Build option: define REGFILE_BYPASS_EN to forward same-cycle write data to
// the read ports (write-first) and report such operands as not busy.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned NREAD  = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we0,
  input  logic [ADDR_W-1:0]        waddr0,
  input  logic [DATA_W-1:0]        wdata0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        waddr1,
  input  logic [DATA_W-1:0]        wdata1,
  input  logic                     alloc_en,
  input  logic [ADDR_W-1:0]        alloc_addr,
  input  logic [NREAD*ADDR_W-1:0]  raddr,
  output logic [NREAD*DATA_W-1:0]  rdata,
  output logic [NREAD-1:0]         rbusy
);

  localparam int unsigned        DEPTH  = 2**ADDR_W;
  localparam logic [ADDR_W-1:0]  ZERO_A = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  pending;
  logic              wr0, wr1, alloc_ok;
  logic [ADDR_W-1:0] ra;
  logic [DATA_W-1:0] rd;
  logic              bz;

  assign wr0      = we0 && (waddr0 != ZERO_A);
  assign wr1      = we1 && (waddr1 != ZERO_A);
  assign alloc_ok = alloc_en && (alloc_addr != ZERO_A);

  regfile_scoreboard #(.ADDR_W(ADDR_W)) u_sb (
    .clk        (clk),
    .rst_n      (rst_n),
    .alloc_en   (alloc_ok),
    .alloc_addr (alloc_addr),
    .clr0_en    (wr0),
    .clr0_addr  (waddr0),
    .clr1_en    (wr1),
    .clr1_addr  (waddr1),
    .pending    (pending)
  );

  // Port 1 is assigned last so it wins when both ports hit the same register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      if (wr0) regs[waddr0] <= wdata0;
      if (wr1) regs[waddr1] <= wdata1;
    end
  end

  always_comb begin
    rdata = '0;
    rbusy = '0;
    ra    = '0;
    rd    = '0;
    bz    = 1'b0;
    for (int unsigned i = 0; i < NREAD; i++) begin
      ra = raddr[i*ADDR_W +: ADDR_W];
      rd = regs[ra];
      bz = pending[ra];
`ifdef REGFILE_BYPASS_EN
      // Forwarding is gated by rst_n: writes in a reset cycle are discarded,
      // so they must not appear on the read ports either.
      if (rst_n && wr0 && (waddr0 == ra)) begin
        rd = wdata0;
        bz = 1'b0;
      end
      if (rst_n && wr1 && (waddr1 == ra)) begin
        rd = wdata1;
        bz = 1'b0;
      end
`endif
      if (ra == ZERO_A) begin
        rd = '0;
        bz = 1'b0;
      end
      rdata[i*DATA_W +: DATA_W] = rd;
      rbusy[i]                  = bz;
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;

  logic             clk;
  logic             rst_n;
  logic             we0, we1, alloc_en;
  logic [AW-1:0]    waddr0, waddr1, alloc_addr;
  logic [DW-1:0]    wdata0, wdata1;
  logic [NR*AW-1:0] raddr;
  logic [NR*DW-1:0] rdata;
  logic [NR-1:0]    rbusy;

  int n_cmp = 0;
  int n_bad = 0;

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NREAD(NR)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .we0        (we0),
    .waddr0     (waddr0),
    .wdata0     (wdata0),
    .we1        (we1),
    .waddr1     (waddr1),
    .wdata1     (wdata1),
    .alloc_en   (alloc_en),
    .alloc_addr (alloc_addr),
    .raddr      (raddr),
    .rdata      (rdata),
    .rbusy      (rbusy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running, need finished");
    $fatal(1, "watchdog");
  end

  task automatic idle();
    we0 = 1'b0; waddr0 = '0; wdata0 = '0;
    we1 = 1'b0; waddr1 = '0; wdata1 = '0;
    alloc_en = 1'b0; alloc_addr = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    raddr = {a1, a0};
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    we0 = 1'b1; waddr0 = 5'd2; wdata0 = 32'hFFFF0000;
    alloc_en = 1'b1; alloc_addr = 5'd6;
    tick();
    tick();
    idle();
    rst_n = 1'b1;
    tick();
    for (int a = 0; a < 32; a++) begin
      rd(5'(a), 5'(31 - a));
      if (rdata !== '0) begin
        $display("FAIL reset_rdata addr=%0d: got %h, need 0", a, rdata);
        n_bad++;
      end
      n_cmp++;
      if (rbusy !== '0) begin
        $display("FAIL reset_rbusy addr=%0d: got %b, need 00", a, rbusy);
        n_bad++;
      end
      n_cmp++;
    end
  endtask

  task automatic test_dual_write();
    we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'h11111111;
    we1 = 1'b1; waddr1 = 5'd5; wdata1 = 32'h22222222;
    tick();
    idle();
    rd(5'd5, 5'd5);
    if (rdata !== {32'h22222222, 32'h22222222}) begin
      $display("FAIL dual_write_same: got %h, need 2222222222222222", rdata);
      n_bad++;
    end
    n_cmp++;
    we0 = 1'b1; waddr0 = 5'd10; wdata0 = 32'hCAFE0001;
    we1 = 1'b1; waddr1 = 5'd11; wdata1 = 32'h0BADF00D;
    tick();
    idle();
    rd(5'd10, 5'd11);
    if (rdata !== {32'h0BADF00D, 32'hCAFE0001}) begin
      $display("FAIL dual_write_diff: got %h, need 0badf00dcafe0001", rdata);
      n_bad++;
    end
    n_cmp++;
    if (rbusy !== 2'b00) begin
      $display("FAIL dual_write_busy: got %b, need 00", rbusy);
      n_bad++;
    end
    n_cmp++;
    rd(5'd11, 5'd5);
    if (rdata !== {32'h22222222, 32'h0BADF00D}) begin
      $display("FAIL independent_ports: got %h, need 222222220badf00d", rdata);
      n_bad++;
    end
    n_cmp++;
  endtask

  task automatic test_zero_reg();
    we0 = 1'b1; waddr0 = 5'd0; wdata0 = 32'hDEADBEEF;
    alloc_en = 1'b1; alloc_addr = 5'd0;
    rd(5'd0, 5'd0);
    if (rdata !== '0 || rbusy !== 2'b00) begin
      $display("FAIL zero_same_cycle: got %h/%b, need 0/00", rdata, rbusy);
      n_bad++;
    end
    n_cmp++;
    tick();
    idle();
    rd(5'd0, 5'd0);
    if (rdata !== '0) begin
      $display("FAIL zero_rdata: got %h, need 0", rdata);
      n_bad++;
    end
    n_cmp++;
    if (rbusy !== 2'b00) begin
      $display("FAIL zero_rbusy: got %b, need 00", rbusy);
      n_bad++;
    end
    n_cmp++;
  endtask

  task automatic test_scoreboard();
    alloc_en = 1'b1; alloc_addr = 5'd7;
    tick();
    idle();
    rd(5'd7, 5'd5);
    if (rbusy !== 2'b01) begin
      $display("FAIL sb_alloc_busy: got %b, need 01", rbusy);
      n_bad++;
    end
    n_cmp++;
    we0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'hA5A5A5A5;
    rd(5'd7, 5'd7);
`ifdef REGFILE_BYPASS_EN
    if (rbusy !== 2'b00 || rdata !== {32'hA5A5A5A5, 32'hA5A5A5A5}) begin
      $display("FAIL sb_write_cycle: got %h/%b, need a5a5a5a5a5a5a5a5/00", rdata, rbusy);
      n_bad++;
    end
`else
    if (rbusy !== 2'b11 || rdata !== '0) begin
      $display("FAIL sb_write_cycle: got %h/%b, need 0/11", rdata, rbusy);
      n_bad++;
    end
`endif
    n_cmp++;
    tick();
    idle();
    rd(5'd7, 5'd7);
    if (rbusy !== 2'b00 || rdata !== {32'hA5A5A5A5, 32'hA5A5A5A5}) begin
      $display("FAIL sb_after_write: got %h/%b, need a5a5a5a5a5a5a5a5/00", rdata, rbusy);
      n_bad++;
    end
    n_cmp++;
    // re-allocate an already pending register, then retire it via port 1
    alloc_en = 1'b1; alloc_addr = 5'd12;
    tick();
    tick();
    idle();
    rd(5'd12, 5'd7);
    if (rbusy !== 2'b01) begin
      $display("FAIL sb_realloc: got %b, need 01", rbusy);
      n_bad++;
    end
    n_cmp++;
    we1 = 1'b1; waddr1 = 5'd12; wdata1 = 32'h00C0FFEE;
    tick();
    idle();
    rd(5'd12, 5'd12);
    if (rbusy !== 2'b00 || rdata !== {32'h00C0FFEE, 32'h00C0FFEE}) begin
      $display("FAIL sb_clear_port1: got %h/%b, need 00c0ffee00c0ffee/00", rdata, rbusy);
      n_bad++;
    end
    n_cmp++;
  endtask

  task automatic test_collision();
    alloc_en = 1'b1; alloc_addr = 5'd9;
    we1 = 1'b1; waddr1 = 5'd9; wdata1 = 32'h00001234;
    tick();
    idle();
    rd(5'd9, 5'd0);
    if (rbusy !== 2'b01) begin
      $display("FAIL collision_busy: got %b, need 01", rbusy);
      n_bad++;
    end
    n_cmp++;
    if (rdata !== {32'h0, 32'h00001234}) begin
      $display("FAIL collision_data: got %h, need 0000000000001234", rdata);
      n_bad++;
    end
    n_cmp++;
  endtask

  task automatic test_reset_mid();
    we0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'h33333333;
    we1 = 1'b1; waddr1 = 5'd4; wdata1 = 32'h44444444;
    tick();
    idle();
    alloc_en = 1'b1; alloc_addr = 5'd3;
    tick();
    alloc_addr = 5'd4;
    tick();
    idle();
    rd(5'd3, 5'd4);
    if (rbusy !== 2'b11 || rdata !== {32'h44444444, 32'h33333333}) begin
      $display("FAIL mid_setup: got %h/%b, need 4444444433333333/11", rdata, rbusy);
      n_bad++;
    end
    n_cmp++;
    rst_n = 1'b0;
    we0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'hFFFFFFFF;
    alloc_en = 1'b1; alloc_addr = 5'd4;
    tick();
    rd(5'd3, 5'd4);
    if (rbusy !== 2'b00 || rdata !== '0) begin
      $display("FAIL mid_in_reset: got %h/%b, need 0/00", rdata, rbusy);
      n_bad++;
    end
    n_cmp++;
    idle();
    rst_n = 1'b1;
    tick();
    rd(5'd3, 5'd4);
    if (rdata !== '0) begin
      $display("FAIL mid_after_data: got %h, need 0", rdata);
      n_bad++;
    end
    n_cmp++;
    if (rbusy !== 2'b00) begin
      $display("FAIL mid_after_busy: got %b, need 00", rbusy);
      n_bad++;
    end
    n_cmp++;
    rd(5'd5, 5'd9);
    if (rdata !== '0 || rbusy !== 2'b00) begin
      $display("FAIL mid_others_cleared: got %h/%b, need 0/00", rdata, rbusy);
      n_bad++;
    end
    n_cmp++;
  endtask

  initial begin
    idle();
    rst_n = 1'b1;
    raddr = '0;
    test_reset();
    test_dual_write();
    test_zero_reg();
    test_scoreboard();
    test_collision();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
